image_write_buffer: RTL and testbench
=====================================

Name: image_write_buffer

Overview:
- Sink end of the two-pixels-per-clock RGB888 stream: consumes VSYNC/HSYNC/DATA_{R,G,B}{0,1} from the image source/processing pipeline.
- Reassembles the frame into an internal byte buffer in bottom-up bitmap order, so reading the buffer back in address order reproduces the source hex layout. Byte order per pixel is R, G, B.
- Reports frame completion and protocol errors, and exposes a registered readback port for the file-dump/checker stage.

Parameters:
- WIDTH, 768, pixels per line; must be even and ≥ 2.
- HEIGHT, 512, lines per frame.
- ADDR_W, 21, byte-address width; must satisfy 2^ADDR_W ≥ WIDTH*HEIGHT*3.
- CNT_W, 20, pair_count width; must satisfy 2^CNT_W > WIDTH*HEIGHT/2.

Ports:
- HCLK  in  1  clock, all logic on posedge.
- HRESET  in  1  asynchronous reset, active-high.
- VSYNC  in  1  frame-start phase; high for ≥ 1 cycle before the first line.
- HSYNC  in  1  data-valid; high means this cycle carries one pixel pair.
- DATA_R0, DATA_G0, DATA_B0  in  8 each  even pixel (column col).
- DATA_R1, DATA_G1, DATA_B1  in  8 each  odd pixel (column col+1).
- rd_addr  in  ADDR_W  readback byte address.
- rd_data  out  8  buffer byte at rd_addr, registered.
- pair_count  out  CNT_W  pixel pairs accepted in the current frame.
- frame_done  out  1  level; high once a full frame has been written.
- line_err  out  1  sticky; a line ended early.
- overflow  out  1  sticky; HSYNC was seen while not accepting data.

Behaviour:
- Reset (HRESET=1, async): state=IDLE; col=0, row=0, pair_count=0, frame_done=0, line_err=0, overflow=0, rd_data=0. Buffer contents are not cleared.
- FSM states: IDLE, FRAME, DONE.
  - IDLE → FRAME when VSYNC=1.
  - FRAME → DONE on the cycle that accepts the last pair (row=HEIGHT-1, col=WIDTH-2).
  - DONE → FRAME when VSYNC=1.
- Any state with VSYNC=1:
  - Counters col, row and pair_count are set to 0.
  - frame_done, line_err and overflow are cleared.
  - HSYNC in the same cycle is ignored; no write and no flag.
  - VSYNC during FRAME aborts the partial frame; already-written bytes are kept.
- FRAME, VSYNC=0, HSYNC=1 (accept):
  - Base address b = 3*WIDTH*(HEIGHT-1-row) + 3*col.
  - Write mem[b..b+2] = R0, G0, B0 and mem[b+3..b+5] = R1, G1, B1. All six bytes are written in the same cycle.
  - pair_count increments by 1.
  - If col=WIDTH-2: col ← 0 and row ← row+1. Otherwise col ← col+2.
- FRAME, HSYNC=0 while col≠0: the partial line is dropped. col ← 0, row unchanged (the line is rewritten by the next data), line_err ← 1. pair_count keeps the accepted pairs.
- FRAME, HSYNC=0 while col=0: idle gap (hsync blanking), no effect.
- HSYNC=1 in IDLE or DONE with VSYNC=0: no write, counters hold, overflow ← 1.
- frame_done: set with the DONE transition, visible the cycle after the last pair is accepted. It stays high until VSYNC or reset.
- Readback:
  - rd_data ← mem[rd_addr] on every posedge; latency is 1 cycle.
  - A read of an address written in the same cycle returns the old byte (read-before-write).
  - rd_addr ≥ WIDTH*HEIGHT*3 returns 0.
- Arithmetic: all addressing is unsigned. row, col and pair_count never exceed a full frame, because DONE blocks further writes.
- Reset mid-frame: returns immediately to IDLE with counters and flags at 0.

Test Plan:
- WIDTH=4, HEIGHT=2: VSYNC 3 cycles, then 4 HSYNC cycles. Pairs in order are (1,2,3,4,5,6), (7,8,9,10,11,12), (13,…), (19,…,24).
  - Required: bytes 12..23 = 1..12 and bytes 0..11 = 13..24.
  - pair_count=4; frame_done=1 one cycle after the 4th pair; state DONE.
- Default 768×512 full stream with pixel value = address hash: all 1,179,648 bytes match expected on readback; pair_count=196608; line_err=0; overflow=0.
- WIDTH=4: HSYNC drops after 1 pair of a line, then 2 full pairs follow.
  - Required: line_err=1; the row is rewritten with the second data set; row advances only after the full line.
- HSYNC pulse after frame_done=1: overflow=1, buffer unchanged, pair_count unchanged. A following VSYNC clears frame_done and overflow and restarts at pair_count=0.
- HRESET asserted mid-frame (after pair 3): outputs go to 0 asynchronously (without waiting for a clock edge). A new VSYNC plus a full frame completes normally with pair_count = frame pairs.
- VSYNC and HSYNC high in the same cycle: no write and no flags. Readback of the address being written that cycle returns the old value, with a 1-cycle rd_data latency checked.

Source files
------------

// File: rtl/image_write_buffer.sv
// rtl/image_write_buffer.sv - RGB888 two-pixel-per-clock sink into a bottom-up frame buffer
// Rows are stored last-line-first so address order matches the source hex dump layout.
module image_write_buffer #(
  parameter int WIDTH  = 768,
  parameter int HEIGHT = 512,
  parameter int ADDR_W = 21,
  parameter int CNT_W  = 20
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              VSYNC,
  input  logic              HSYNC,
  input  logic [7:0]        DATA_R0,
  input  logic [7:0]        DATA_G0,
  input  logic [7:0]        DATA_B0,
  input  logic [7:0]        DATA_R1,
  input  logic [7:0]        DATA_G1,
  input  logic [7:0]        DATA_B1,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data,
  output logic [CNT_W-1:0]  pair_count,
  output logic              frame_done,
  output logic              line_err,
  output logic              overflow
);

  localparam int BYTES = WIDTH * HEIGHT * 3;
  localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int COL_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam int ROW_W = $clog2(HEIGHT + 1);

  typedef enum logic [1:0] {S_IDLE, S_FRAME, S_DONE} state_t;

  state_t             r_state;
  logic [COL_W-1:0]   r_col;
  logic [ROW_W-1:0]   r_row;
  logic [CNT_W-1:0]   r_pair_count;
  logic               r_frame_done;
  logic               r_line_err;
  logic               r_overflow;
  logic [7:0]         r_rd_data;
  logic [7:0]         r_mem [0:BYTES-1];

  logic               w_accept;
  logic               w_last_col;
  logic               w_last_pair;
  logic               w_rd_ok;
  logic [ADDR_W-1:0]  w_row_inv;
  logic [ADDR_W-1:0]  w_base;

  assign w_accept    = (r_state == S_FRAME) && !VSYNC && HSYNC;
  assign w_last_col  = (r_col == COL_W'(WIDTH - 2));
  assign w_last_pair = w_last_col && (r_row == ROW_W'(HEIGHT - 1));
  assign w_row_inv   = ADDR_W'(HEIGHT - 1 - int'(r_row));
  assign w_base      = ADDR_W'(3 * WIDTH) * w_row_inv + ADDR_W'(3) * ADDR_W'(r_col);
  assign w_rd_ok     = ({1'b0, rd_addr} < (ADDR_W + 1)'(BYTES));

  always_ff @(posedge HCLK) begin
    if (w_accept) begin
      r_mem[IDX_W'(w_base)]              <= DATA_R0;
      r_mem[IDX_W'(w_base + ADDR_W'(1))] <= DATA_G0;
      r_mem[IDX_W'(w_base + ADDR_W'(2))] <= DATA_B0;
      r_mem[IDX_W'(w_base + ADDR_W'(3))] <= DATA_R1;
      r_mem[IDX_W'(w_base + ADDR_W'(4))] <= DATA_G1;
      r_mem[IDX_W'(w_base + ADDR_W'(5))] <= DATA_B1;
    end
  end

  // Nonblocking read alongside the write block gives read-before-write.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_rd_data <= 8'd0;
    end else begin
      r_rd_data <= w_rd_ok ? r_mem[IDX_W'(rd_addr)] : 8'd0;
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_state      <= S_IDLE;
      r_col        <= '0;
      r_row        <= '0;
      r_pair_count <= '0;
      r_frame_done <= 1'b0;
      r_line_err   <= 1'b0;
      r_overflow   <= 1'b0;
    end else if (VSYNC) begin
      r_state      <= S_FRAME;
      r_col        <= '0;
      r_row        <= '0;
      r_pair_count <= '0;
      r_frame_done <= 1'b0;
      r_line_err   <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      case (r_state)
        S_FRAME: begin
          if (HSYNC) begin
            r_pair_count <= r_pair_count + CNT_W'(1);
            if (w_last_col) begin
              r_col <= '0;
              r_row <= r_row + ROW_W'(1);
            end else begin
              r_col <= r_col + COL_W'(2);
            end
            if (w_last_pair) begin
              r_state      <= S_DONE;
              r_frame_done <= 1'b1;
            end
          end else if (r_col != '0) begin
            // Short line: restart it so the next data overwrites the same row.
            r_col      <= '0;
            r_line_err <= 1'b1;
          end
        end
        default: begin
          if (HSYNC) r_overflow <= 1'b1;
        end
      endcase
    end
  end

  assign rd_data    = r_rd_data;
  assign pair_count = r_pair_count;
  assign frame_done = r_frame_done;
  assign line_err   = r_line_err;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_image_write_buffer.sv
// tb/tb_image_write_buffer.sv - directed bench for image_write_buffer on a 4x2 frame
module tb_image_write_buffer;

  localparam int WIDTH  = 4;
  localparam int HEIGHT = 2;
  localparam int ADDR_W = 5;
  localparam int CNT_W  = 3;

  logic              HCLK = 1'b0;
  logic              HRESET;
  logic              VSYNC;
  logic              HSYNC;
  logic [7:0]        DATA_R0, DATA_G0, DATA_B0, DATA_R1, DATA_G1, DATA_B1;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        rd_data;
  logic [CNT_W-1:0]  pair_count;
  logic              frame_done;
  logic              line_err;
  logic              overflow;

  int total = 0;
  int bad   = 0;

  image_write_buffer #(
    .WIDTH(WIDTH), .HEIGHT(HEIGHT), .ADDR_W(ADDR_W), .CNT_W(CNT_W)
  ) dut (
    .HCLK(HCLK), .HRESET(HRESET), .VSYNC(VSYNC), .HSYNC(HSYNC),
    .DATA_R0(DATA_R0), .DATA_G0(DATA_G0), .DATA_B0(DATA_B0),
    .DATA_R1(DATA_R1), .DATA_G1(DATA_G1), .DATA_B1(DATA_B1),
    .rd_addr(rd_addr), .rd_data(rd_data), .pair_count(pair_count),
    .frame_done(frame_done), .line_err(line_err), .overflow(overflow)
  );

  always #5 HCLK = ~HCLK;

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_data(input logic [7:0] v);
    DATA_R0 = v;       DATA_G0 = v + 8'd1; DATA_B0 = v + 8'd2;
    DATA_R1 = v + 8'd3; DATA_G1 = v + 8'd4; DATA_B1 = v + 8'd5;
  endtask

  task automatic pair(input logic [7:0] v);
    set_data(v);
    HSYNC = 1'b1;
    step();
    HSYNC = 1'b0;
  endtask

  task automatic rdchk(input string tag, input int addr, input int exp);
    rd_addr = ADDR_W'(addr);
    step();
    chk(tag, 32'(rd_data), 32'(exp));
  endtask

  initial begin
    HRESET = 1'b1; VSYNC = 1'b0; HSYNC = 1'b0; rd_addr = '0;
    set_data(8'd0);
    step(); step();
    chk("rst_rd_data", 32'(rd_data), 0);
    chk("rst_pair_count", 32'(pair_count), 0);
    chk("rst_frame_done", 32'(frame_done), 0);
    chk("rst_line_err", 32'(line_err), 0);
    chk("rst_overflow", 32'(overflow), 0);
    HRESET = 1'b0;
    step();

    // Frame 1: pairs start at 1, 7, 13, 19.
    VSYNC = 1'b1; step(); step(); step(); VSYNC = 1'b0;
    pair(8'd1); pair(8'd7); pair(8'd13);
    chk("f1_done_early", 32'(frame_done), 0);
    pair(8'd19);
    chk("f1_frame_done", 32'(frame_done), 1);
    chk("f1_pair_count", 32'(pair_count), 4);
    chk("f1_line_err", 32'(line_err), 0);
    for (int a = 0; a < 24; a++)
      rdchk($sformatf("f1_byte%0d", a), a, (a < 12) ? a + 13 : a - 11);
    rdchk("oob_24", 24, 0);
    rdchk("oob_31", 31, 0);

    // HSYNC after completion only raises overflow.
    pair(8'hA0);
    chk("ovf_flag", 32'(overflow), 1);
    chk("ovf_pair_count", 32'(pair_count), 4);
    chk("ovf_frame_done", 32'(frame_done), 1);
    rdchk("ovf_byte0", 0, 13);
    rdchk("ovf_byte12", 12, 1);
    VSYNC = 1'b1; step(); VSYNC = 1'b0;
    chk("vs_frame_done", 32'(frame_done), 0);
    chk("vs_overflow", 32'(overflow), 0);
    chk("vs_pair_count", 32'(pair_count), 0);

    // Short line then a full rewrite of the same row.
    pair(8'd101);
    step();
    chk("le_flag", 32'(line_err), 1);
    chk("le_pair_count", 32'(pair_count), 1);
    pair(8'd111); pair(8'd121);
    chk("le_pair_count3", 32'(pair_count), 3);
    pair(8'd131);
    chk("le_pair_count4", 32'(pair_count), 4);
    chk("le_not_done", 32'(frame_done), 0);
    rdchk("le_byte12", 12, 111);
    rdchk("le_byte17", 17, 116);
    rdchk("le_byte18", 18, 121);
    rdchk("le_byte0", 0, 131);
    rdchk("le_byte6", 6, 19);

    // Asynchronous reset mid-frame after three pairs.
    VSYNC = 1'b1; step(); VSYNC = 1'b0;
    pair(8'd141); pair(8'd151);
    rd_addr = 5'd12;
    pair(8'd161);
    chk("pre_rst_pair_count", 32'(pair_count), 3);
    chk("pre_rst_rd_data", 32'(rd_data), 141);
    HRESET = 1'b1;
    #2;
    chk("arst_pair_count", 32'(pair_count), 0);
    chk("arst_rd_data", 32'(rd_data), 0);
    chk("arst_frame_done", 32'(frame_done), 0);
    step();
    HRESET = 1'b0;
    VSYNC = 1'b1; step(); VSYNC = 1'b0;
    pair(8'd201); pair(8'd207); pair(8'd213); pair(8'd219);
    chk("f2_pair_count", 32'(pair_count), 4);
    chk("f2_frame_done", 32'(frame_done), 1);
    rdchk("f2_byte12", 12, 201);
    rdchk("f2_byte0", 0, 213);
    rdchk("f2_byte23", 23, 212);

    // VSYNC with HSYNC: no write, no flags; then read-before-write.
    rd_addr = 5'd12;
    set_data(8'h55);
    VSYNC = 1'b1; HSYNC = 1'b1;
    step();
    VSYNC = 1'b0; HSYNC = 1'b0;
    chk("vh_overflow", 32'(overflow), 0);
    chk("vh_line_err", 32'(line_err), 0);
    chk("vh_pair_count", 32'(pair_count), 0);
    chk("vh_rd_nowrite", 32'(rd_data), 201);
    pair(8'h31);
    chk("rbw_old", 32'(rd_data), 201);
    chk("rbw_pair_count", 32'(pair_count), 1);
    rd_addr = 5'd13;
    #2;
    chk("lat_hold", 32'(rd_data), 201);
    step();
    chk("lat_new", 32'(rd_data), 8'h32);
    rdchk("rbw_byte12", 12, 8'h31);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
